tdm_mux_8way: RTL and testbench
===============================

# tdm_mux_8way

- Transmit end of the 8-way time-division link; the 8-way demultiplexer is the receive end.
- Each frame, captures eight 1-bit channels coherently and serialises them onto `out0`, one slot per enabled clock.
- Drives slot select `s2,s1,s0` alongside, so the downstream demux can route each bit back to its channel.
- Marks each frame with a frame-start strobe, and optionally appends an even-parity slot.

## Interface
Parameters: none.

Ports:
- `clk`  input  1  clock, rising-edge active.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  slot advance enable; one slot is emitted per `clk` edge with `en`=1.
- `sync`  input  1  synchronous frame restart; forces the next emitted slot to be slot 0.
- `in7`..`in0`  input  1 each  channel data.
- `out0`  output  1  serial data for the current slot.
- `s2,s1,s0`  output  1 each  slot index of `out0` (`s2` is MSB).
- `frame`  output  1  high for exactly the slot-0 output cycle.
- `valid`  output  1  high when `out0`/`s*` carry a freshly emitted slot.
- `par`  output  1  high during the parity slot; constant 0 when parity is compiled out.

## Operation
Internal state:
- `cnt`: slot counter. 3 bits; 4 bits with parity compiled in.
- `shadow[7:0]`: frame capture register.

Reset (`rst`=1, asynchronous, any time, including mid-frame):
- `cnt`=0, `shadow`=0.
- `out0`=0, `s2,s1,s0`=000, `frame`=0, `valid`=0, `par`=0.
- After release, the first edge with `en`=1 emits slot 0.

On each rising edge of `clk`, with `rst`=0:
- Effective slot: `e` = 0 if `sync`=1, else `e` = `cnt`.
- `en`=1, `e`=0:
  - `shadow` <= {`in7`..`in0`}.
  - `out0` <= `in0` (live value).
  - `s`=000, `frame`=1.
- `en`=1, `e` = 1..7:
  - `out0` <= `shadow[e]`.
  - `s` <= `e`, `frame`=0.
  - Inputs are ignored; channel changes mid-frame are not seen until the next frame.
- `en`=1, any slot:
  - `valid`=1.
  - `cnt` <= `e`+1, wrapping 7→0 (or 8→0 with parity).
- `en`=0:
  - `valid`=0, `frame`=0, `par`=0.
  - `out0` and `s*` hold their values.
  - `cnt` <= 0 if `sync`=1, else holds.
  - `shadow` holds.

Boundary cases:
- `sync`=1 with `en`=1 at slot 0 is equivalent to a normal slot 0; the frame is not aborted twice.
- `sync` mid-frame truncates the current frame; the truncated slots are never sent.
- `en` toggling mid-frame stretches the frame; the slot order is unchanged.

## Timing
- Fully registered outputs.
  - Slot k appears on the outputs one `clk` after the edge that emits it.
  - It stays there until the next enabled edge.
- Frame length:
  - 8 enabled cycles without parity.
  - 9 enabled cycles with parity.
  - With `en` held high, `frame` pulses every 8 (or 9) clocks.
- Channel-to-output latency: channel data sampled at the slot-0 edge appears on `out0` for channel i exactly i enabled edges later.
- No combinational path from inputs to outputs.

## Configuration
`TDM_PARITY_EN`:
- Defined:
  - A ninth slot (`cnt`=8) follows slot 7.
  - In it, `out0` = XOR of `shadow[7:0]` (even parity over the frame), `s`=000, `par`=1, `frame`=0, `valid`=1.
  - `cnt` wraps 8→0.
- Undefined:
  - 8-slot frame, `cnt` wraps 7→0.
  - `par` tied to 0.

## Test plan
- Reset mid-frame:
  - Stimulus: `en`=1, inputs=8'hA5, assert `rst` at slot 4.
  - Response: all outputs 0 immediately.
  - After release, first emitted slot is `s`=000 with `frame`=1.
- Basic frame:
  - Stimulus: `in7..in0`=8'b1010_0101, `en`=1 for 8 clocks.
  - Response: `out0` sequence 1,0,1,0,0,1,0,1 with `s`=0..7, `frame` only on slot 0, `valid`=1 throughout.
- Coherent capture:
  - Stimulus: change inputs to 8'hFF at slot 3.
  - Response: slots 3–7 still carry the 8'hA5 bits; the next frame carries all 1s.
- Enable gaps:
  - Stimulus: drop `en` for 2 clocks after slot 2.
  - Response: `valid`=0 and `out0`/`s` hold slot 2 during the gap; slot 3 follows when `en` returns.
- Sync:
  - Stimulus: `sync`=1 with `en`=1 at slot 5.
  - Response: that edge emits slot 0 with a fresh capture and `frame`=1.
  - Stimulus: `sync`=1 with `en`=0.
  - Response: the next enabled edge emits slot 0.
- Parity (`TDM_PARITY_EN` defined):
  - Stimulus: inputs 8'h07.
  - Response: ninth slot `out0`=1, `par`=1; with 8'h03 it is `out0`=0; `frame` period is 9.

Source files
------------

// File: rtl/tdm_mux_8way.sv
// tdm_mux_8way: transmit end of an 8-way time-division link.
// Captures eight 1-bit channels once per frame (at slot 0) and serialises
// them onto out0, one slot per enabled clock, with the slot index on s2..s0.
// The frame strobe marks slot 0. Every output is registered, so there is no
// combinational path from any input to any output.
// Compile-time option: define TDM_PARITY_EN to append a ninth, even-parity
// slot after slot 7. When it is undefined, frames are 8 slots long and par
// is tied low.
module tdm_mux_8way (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync,
  input  logic in7,
  input  logic in6,
  input  logic in5,
  input  logic in4,
  input  logic in3,
  input  logic in2,
  input  logic in1,
  input  logic in0,
  output logic out0,
  output logic s2,
  output logic s1,
  output logic s0,
  output logic frame,
  output logic valid,
  output logic par
);

`ifdef TDM_PARITY_EN
  // Slots 0..7 carry data and slot 8 carries parity.
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_SLOT = 4'd8;
`else
  // Slots 0..7 carry data only.
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_SLOT = 3'd7;
`endif

  // Slot counter and the frame capture register.
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [7:0]       shadow_reg;
  logic [7:0]       shadow_next;

  // Output registers.
  logic             out0_reg;
  logic [2:0]       s_reg;
  logic             frame_reg;
  logic             valid_reg;

  // Combinational decode of the slot being emitted on this edge.
  logic [CNT_W-1:0] slot_eff;
  logic             slot_zero;
  logic             parity_slot;
  logic             capture;
  logic             out0_next;
  logic [2:0]       s_next;
  logic [7:0]       chan;

  assign chan = {in7, in6, in5, in4, in3, in2, in1, in0};

  // sync overrides the counter, so the edge it arrives on emits slot 0.
  assign slot_eff  = sync ? '0 : cnt_reg;
  assign slot_zero = (slot_eff == '0);
  assign capture   = en && slot_zero;

`ifdef TDM_PARITY_EN
  assign parity_slot = (slot_eff == LAST_SLOT);
`else
  assign parity_slot = 1'b0;
`endif

  // Wrap after the last slot of the frame. The >= compare also returns
  // the counter to 0 from any value that should never occur.
  assign cnt_next = (slot_eff >= LAST_SLOT) ? '0 : slot_eff + 1'b1;

  // Per-bit capture. All eight channels load together at slot 0, so channel
  // changes mid-frame wait for the next frame.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_capture
      assign shadow_next[gi] = capture ? chan[gi] : shadow_reg[gi];
    end
  endgenerate

  // Select the serial bit and the slot index for this edge.
  always_comb begin
    out0_next = shadow_reg[slot_eff[2:0]];
    s_next    = slot_eff[2:0];
    if (slot_zero) begin
      // Slot 0 carries the live in0 bit, which is also being captured now.
      out0_next = in0;
      s_next    = 3'd0;
    end else if (parity_slot) begin
      // Even parity over the frame captured at slot 0.
      out0_next = ^shadow_reg;
      s_next    = 3'd0;
    end
  end

  // Slot counter and capture register. With en low, only sync can move
  // the counter, and it moves it back to slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      shadow_reg <= '0;
    end else begin
      shadow_reg <= shadow_next;
      if (en) begin
        cnt_reg <= cnt_next;
      end else if (sync) begin
        cnt_reg <= '0;
      end
    end
  end

  // Registered outputs. Data and index hold through enable gaps, and the
  // strobes are low whenever no slot is emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0_reg  <= 1'b0;
      s_reg     <= 3'd0;
      frame_reg <= 1'b0;
      valid_reg <= 1'b0;
    end else if (en) begin
      out0_reg  <= out0_next;
      s_reg     <= s_next;
      frame_reg <= slot_zero;
      valid_reg <= 1'b1;
    end else begin
      frame_reg <= 1'b0;
      valid_reg <= 1'b0;
    end
  end

`ifdef TDM_PARITY_EN
  logic par_reg;

  // Parity-slot flag, registered alongside the data so it lines up with out0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_reg <= 1'b0;
    end else begin
      par_reg <= en && parity_slot;
    end
  end

  assign par = par_reg;
`else
  assign par = 1'b0;
`endif

  assign out0  = out0_reg;
  assign s2    = s_reg[2];
  assign s1    = s_reg[1];
  assign s0    = s_reg[0];
  assign frame = frame_reg;
  assign valid = valid_reg;

endmodule

// File: tb/tb_tdm_mux_8way.sv
// tb_tdm_mux_8way: directed and randomised bench for tdm_mux_8way.
// Each step drives the inputs on the falling edge and pushes the expected
// outputs onto a scoreboard. One time unit after the next rising edge, it
// pops that entry and compares it with the outputs.
module tb_tdm_mux_8way;

`ifdef TDM_PARITY_EN
  localparam int NSLOT = 9;
`else
  localparam int NSLOT = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic sync;
  logic in7, in6, in5, in4, in3, in2, in1, in0;
  logic out0, s2, s1, s0, frame, valid, par;

  tdm_mux_8way dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .sync  (sync),
    .in7   (in7),
    .in6   (in6),
    .in5   (in5),
    .in4   (in4),
    .in3   (in3),
    .in2   (in2),
    .in1   (in1),
    .in0   (in0),
    .out0  (out0),
    .s2    (s2),
    .s1    (s1),
    .s0    (s0),
    .frame (frame),
    .valid (valid),
    .par   (par)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: slot counter, captured frame and the held outputs.
  int         m_cnt;
  logic [7:0] m_shadow;
  logic       m_out0;
  logic [2:0] m_s;

  // Scoreboard entries are {out0, s[2:0], frame, valid, par}.
  logic [6:0] exp_q[$];
  string      tag_q[$];

  function automatic logic [6:0] obs_vec();
    return {out0, s2, s1, s0, frame, valid, par};
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed {out0,s,frame,valid,par}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_shadow = 8'h00;
    m_out0   = 1'b0;
    m_s      = 3'd0;
  endtask

  // Drive one clock of stimulus, predict the outputs, and compare after the edge.
  task automatic step(input logic e_en, input logic e_sync, input logic [7:0] d, input string tag);
    int   e;
    logic fr;
    logic pr;
    @(negedge clk);
    en   = e_en;
    sync = e_sync;
    {in7, in6, in5, in4, in3, in2, in1, in0} = d;
    e  = e_sync ? 0 : m_cnt;
    fr = 1'b0;
    pr = 1'b0;
    if (e_en) begin
      if (e == 0) begin
        m_shadow = d;
        m_out0   = d[0];
        m_s      = 3'd0;
        fr       = 1'b1;
      end else if (e == 8) begin
        m_out0 = ^m_shadow;
        m_s    = 3'd0;
        pr     = 1'b1;
      end else begin
        m_out0 = m_shadow[e];
        m_s    = 3'(e);
      end
      m_cnt = (e == NSLOT - 1) ? 0 : e + 1;
    end else if (e_sync) begin
      m_cnt = 0;
    end
    exp_q.push_back({m_out0, m_s, fr, e_en, pr});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check(tag_q.pop_front(), obs_vec(), exp_q.pop_front());
  endtask

  task automatic run_frame(input logic [7:0] d, input string name);
    for (int k = 0; k < NSLOT; k++) begin
      step(1'b1, 1'b0, d, $sformatf("%s s%0d", name, k));
    end
  endtask

  initial begin
    // Power-on reset: every output must be low.
    rst  = 1'b1;
    en   = 1'b0;
    sync = 1'b0;
    {in7, in6, in5, in4, in3, in2, in1, in0} = 8'h00;
    model_reset();
    #2;
    check("reset outputs", obs_vec(), 7'b0);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame with 8'hA5: out0 runs 1,0,1,0,0,1,0,1 across s = 0..7.
    run_frame(8'hA5, "basic");

    // Coherent capture: the inputs change to 8'hFF at slot 3, but this
    // frame still carries 8'hA5.
    for (int k = 0; k < NSLOT; k++) begin
      step(1'b1, 1'b0, (k < 3) ? 8'hA5 : 8'hFF, $sformatf("coherent s%0d", k));
    end
    run_frame(8'hFF, "all-ones");

    // Enable gap: slot 2 is followed by two idle clocks, and then slot 3.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'h3C, $sformatf("gap s%0d", k));
    step(1'b0, 1'b0, 8'hC3, "gap idle0");
    step(1'b0, 1'b0, 8'hC3, "gap idle1");
    for (int k = 3; k < NSLOT; k++) step(1'b1, 1'b0, 8'hC3, $sformatf("gap s%0d", k));

    // sync with en=1 where slot 5 was due: a fresh capture is emitted as slot 0.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 8'h5A, $sformatf("sync-pre s%0d", k));
    step(1'b1, 1'b1, 8'h96, "sync-en restart");
    for (int k = 1; k < 4; k++) step(1'b1, 1'b0, 8'h00, $sformatf("sync-post s%0d", k));

    // sync with en=0: the next enabled edge emits slot 0.
    step(1'b0, 1'b1, 8'h00, "sync-idle");
    step(1'b1, 1'b0, 8'h69, "sync-idle next s0");
    step(1'b1, 1'b0, 8'h00, "sync-idle next s1");

    // sync at slot 0 behaves like an ordinary slot 0.
    for (int k = 2; k < NSLOT; k++) step(1'b1, 1'b0, 8'h00, $sformatf("finish s%0d", k));
    step(1'b1, 1'b1, 8'hE1, "sync-at-s0");
    step(1'b1, 1'b0, 8'h00, "sync-at-s0 s1");
    for (int k = 2; k < NSLOT; k++) step(1'b1, 1'b0, 8'h00, $sformatf("sync-at-s0 s%0d", k));

`ifdef TDM_PARITY_EN
    // Parity slot: 8'h07 gives out0=1 and 8'h03 gives out0=0.
    run_frame(8'h07, "parity07");
    run_frame(8'h03, "parity03");
`endif

    // Randomised traffic with enable gaps and occasional sync.
    for (int k = 0; k < 60; k++) begin
      step(($urandom_range(3) != 0), ($urandom_range(15) == 0), 8'($urandom),
           $sformatf("random %0d", k));
    end

    // Reset mid-frame: assert rst after slot 4 is out.
    step(1'b1, 1'b1, 8'hA5, "rstmid s0");
    for (int k = 1; k < 5; k++) step(1'b1, 1'b0, 8'hA5, $sformatf("rstmid s%0d", k));
    #1;
    rst = 1'b1;
    #1;
    check("rstmid async outputs", obs_vec(), 7'b0);
    @(posedge clk);
    #1;
    check("rstmid held outputs", obs_vec(), 7'b0);
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
    model_reset();
    run_frame(8'hA5, "post-reset");

    check("scoreboard drained", 7'(exp_q.size()), 7'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
